// File: rtl/waveform_readout.sv
// Reader for the circular capture RAM: streams a 2-byte header, then
// nsmp samples from each enabled channel, starting triggerpoint samples
// before the recorded trigger address.
//
// Ports:
//   clk, rstn             clock, async active-low reset
//   start_read, abort     command pulse / cancel the readout
//   data_ready            capture complete, RAM contents stable
//   wraddress_triggerpoint, triggerpoint, nsmp, chan_mask  readout setup
//   ram_q1..ram_q4        RAM read data, channels 0..3
//   rden, rdaddress       RAM read port
//   tx_data, tx_valid, tx_ready  byte stream to the host interface
//   busy, done            status
module waveform_readout #(
   parameter int          ram_width = 10,
   parameter int          RD_LAT    = 2,
   parameter logic [7:0]  HDR_MARK  = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start_read,
   input  logic                 abort,
   input  logic                 data_ready,
   input  logic [ram_width-1:0] wraddress_triggerpoint,
   input  logic [ram_width-1:0] triggerpoint,
   input  logic [ram_width-1:0] nsmp,
   input  logic [3:0]           chan_mask,
   input  logic [7:0]           ram_q1,
   input  logic [7:0]           ram_q2,
   input  logic [7:0]           ram_q3,
   input  logic [7:0]           ram_q4,
   output logic                 rden,
   output logic [ram_width-1:0] rdaddress,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_ADDR, S_WAIT, S_SEND, S_FIN
   } state_t;

   localparam logic [ram_width-1:0] ONE      = 1;
   localparam logic [2:0]           LAT_LAST = 3'(RD_LAT - 1);

   state_t               state, state_n;
   logic [ram_width-1:0] start_l, nsmp_l, idx, addr;
   logic [3:0]           mask_l;
   logic [1:0]           ch, first_ch, nxt_ch;
   logic                 has_nxt, last_smp, go;
   logic [2:0]           lat_cnt;
   logic [7:0]           samp_r, q_sel;

   assign go        = start_read && data_ready;
   assign last_smp  = (idx == nsmp_l - ONE);
   assign rdaddress = addr;

   // lowest enabled channel, and the next enabled one above ch
   always_comb begin
      first_ch = 2'd0;
      nxt_ch   = 2'd0;
      has_nxt  = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (mask_l[i]) first_ch = 2'(i);
         if (mask_l[i] && 2'(i) > ch) begin
            nxt_ch  = 2'(i);
            has_nxt = 1'b1;
         end
      end
   end

   always_comb begin
      q_sel = ram_q1;
      unique case (ch)
         2'd0: q_sel = ram_q1;
         2'd1: q_sel = ram_q2;
         2'd2: q_sel = ram_q3;
         2'd3: q_sel = ram_q4;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      rden     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         S_IDLE: if (go) state_n = S_HDR0;
         S_HDR0: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = HDR_MARK;
            if (tx_ready) state_n = S_HDR1;
         end
         S_HDR1: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = {4'b0, mask_l};
            if (tx_ready)
               state_n = (mask_l == 4'd0 || nsmp_l == '0) ? S_FIN : S_ADDR;
         end
         S_ADDR: begin
            busy    = 1'b1;
            rden    = 1'b1;
            state_n = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            rden = 1'b1;
            if (lat_cnt == LAT_LAST) state_n = S_SEND;
         end
         S_SEND: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = samp_r;
            if (tx_ready)
               state_n = (!last_smp || has_nxt) ? S_ADDR : S_FIN;
         end
         S_FIN: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      if (state != S_IDLE && abort) state_n = S_IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         start_l <= '0;
         nsmp_l  <= '0;
         mask_l  <= 4'd0;
         ch      <= 2'd0;
         idx     <= '0;
         addr    <= '0;
         lat_cnt <= 3'd0;
         samp_r  <= 8'h00;
      end else begin
         if (state == S_IDLE && go) begin
            start_l <= wraddress_triggerpoint - triggerpoint;
            nsmp_l  <= nsmp;
            mask_l  <= chan_mask;
         end
         if (state == S_HDR1 && tx_ready) begin
            ch   <= first_ch;
            idx  <= '0;
            addr <= start_l;
         end
         if (state == S_ADDR) lat_cnt <= 3'd0;
         if (state == S_WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
            if (lat_cnt == LAT_LAST) samp_r <= q_sel;
         end
         if (state == S_SEND && tx_ready) begin
            if (!last_smp) begin
               idx  <= idx + ONE;
               addr <= addr + ONE;
            end else begin
               ch   <= nxt_ch;
               idx  <= '0;
               addr <= start_l;
            end
         end
      end
   end

endmodule

// File: doc/waveform_readout.md
Name: waveform_readout

Overview:
- Reader side of the capture RAM that the ADC acquisition block fills as a circular buffer.
- After a capture completes (data_ready high), a start_read command makes this block walk the RAM, beginning triggerpoint samples before the recorded trigger address.
- It emits a 2-byte header, then the samples of each enabled channel, over a valid/ready byte stream to the host-interface (USB/serial) block.
- It owns the shared RAM read port (rden/rdaddress) and the per-channel read data.

Parameters:
- ram_width, 10, RAM address width; buffer depth 2^ram_width.
- RD_LAT, 2, clocks from address/rden registered to ram_q valid; range 1..4.
- HDR_MARK, 8'hA5, first header byte.

Ports:
- clk  in  1  single clock for the block and the RAM read port.
- rstn  in  1  asynchronous active-low reset.
- start_read  in  1  one-cycle command pulse.
- abort  in  1  cancel the readout in progress.
- data_ready  in  1  capture complete, RAM contents stable.
- wraddress_triggerpoint  in  ram_width  RAM address at which the trigger occurred.
- triggerpoint  in  ram_width  number of pre-trigger samples.
- nsmp  in  ram_width  samples to send per channel.
- chan_mask  in  4  channels to send; bit i = channel i.
- ram_q1, ram_q2, ram_q3, ram_q4  in  8 each  RAM read data for channels 0..3.
- rden  out  1  RAM read enable.
- rdaddress  out  ram_width  RAM read address.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte.
- busy  out  1  high from IDLE exit until return to IDLE.
- done  out  1  one-cycle pulse when the readout completes.

Behaviour:
- Reset (async, rstn=0): state IDLE; rden=0, rdaddress=0, tx_data=0, tx_valid=0, busy=0, done=0; all internal counters cleared.
- States: IDLE, HDR0, HDR1, ADDR, WAIT, SEND, FIN.
- IDLE:
  - start_read && data_ready → latch start = (wraddress_triggerpoint - triggerpoint) mod 2^ram_width; latch nsmp_l=nsmp and mask_l=chan_mask; busy=1; go to HDR0.
  - start_read with data_ready=0 is ignored.
  - start_read while not IDLE is ignored; latched values never change mid-readout.
- HDR0: tx_data=HDR_MARK, tx_valid=1; on accept (tx_valid && tx_ready) go to HDR1.
- HDR1: tx_data={4'b0, mask_l}; on accept:
  - if mask_l==0 or nsmp_l==0, go to FIN;
  - else set ch = lowest set bit of mask_l, idx=0, addr=start, go to ADDR.
- Header bytes are back-to-back: HDR1 is valid the cycle after HDR0 is accepted.
- ADDR: rdaddress=addr, rden=1, tx_valid=0; go to WAIT next cycle.
- WAIT: rden stays 1 and rdaddress is held for RD_LAT cycles. On the last WAIT cycle, register tx_data = ram_q(ch+1) and set tx_valid=1 the following cycle; go to SEND.
- SEND:
  - tx_data and tx_valid are held stable while tx_ready=0; rden=0.
  - On accept with idx < nsmp_l-1: idx+1, addr+1 (wraps from 2^ram_width-1 to 0), go to ADDR.
  - On accept with idx == nsmp_l-1: ch = next higher set bit of mask_l, idx=0, addr=start, go to ADDR; if no higher bit is set, go to FIN.
- Sample throughput: after a sample byte is accepted, tx_valid is low for exactly RD_LAT+1 cycles and reasserts on the (RD_LAT+2)th cycle.
- FIN: done=1 for one cycle, busy=0, back to IDLE.
- Output count per readout: 2 + popcount(mask_l)*nsmp_l bytes.
- abort:
  - In any non-IDLE state, abort takes priority over everything else.
  - Next cycle: IDLE, tx_valid=0, rden=0, busy=0, no done pulse. A partially sent byte is dropped.
- data_ready falling mid-readout is ignored; the controller guarantees no new capture starts while busy.
- Address arithmetic is ram_width-bit modulo throughout; triggerpoint > wraddress_triggerpoint wraps correctly.

Test Plan:
- Basic readout, wrap: ram_width=10, RD_LAT=2, wraddress_triggerpoint=1, triggerpoint=2, nsmp=4, chan_mask=4'b0001, tx_ready=1 → bytes A5, 01, then RAM1[1023], [0], [1], [2]; rdaddress sequence 1023,0,1,2; exactly 3 idle cycles between sample bytes; done pulses once.
- Multi-channel ordering: chan_mask=4'b1010, nsmp=3, start=100 → A5, 0A, ch1[100..102], ch3[100..102]; total 8 bytes.
- Backpressure: tx_ready=0 for 10 cycles during the 2nd sample byte → tx_data/tx_valid stable and rden=0 throughout; stream content unchanged.
- Degenerate: nsmp=0 or chan_mask=0 → only A5 and the mask byte, then done; rden never asserted.
- Guards: start_read with data_ready=0 → no activity; start_read while busy → ignored, output identical to the uninterrupted run.
- abort in WAIT and in SEND → IDLE next cycle, tx_valid=0, no done; a fresh start_read gives a full correct readout. rstn low mid-SEND → all outputs at reset values asynchronously.
